// File: rtl/fifo_pkg.sv
// fifo_pkg: shared dual-clock FIFO constants.
// ALMOST_FULL_EN mirrors whether FIFO_ALMOST_FULL_EN is defined for this build.
package fifo_pkg;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int AF_MARGIN_DEF = 4;
  localparam int SYNC_STAGES = 2;
`ifdef FIFO_ALMOST_FULL_EN
  localparam bit ALMOST_FULL_EN = 1'b1;
`else
  localparam bit ALMOST_FULL_EN = 1'b0;
`endif
endpackage

// File: rtl/write_ctrl_if.sv
// write_ctrl_if: producer-facing and cross-domain signals of the FIFO write side.
interface write_ctrl_if #(parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH_DEF);
  logic w_push;
  logic [ADDR_WIDTH:0] r_ptr_gray;
  logic w_en;
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH:0] w_ptr_gray;
  logic w_full;
  logic w_almost_full;
  logic [ADDR_WIDTH:0] w_level;
  logic w_overflow;
  modport master (
    output w_push, r_ptr_gray,
    input w_en, w_ptr, w_ptr_gray, w_full, w_almost_full, w_level, w_overflow
  );
  modport slave (
    input w_push, r_ptr_gray,
    output w_en, w_ptr, w_ptr_gray, w_full, w_almost_full, w_level, w_overflow
  );
endinterface

// File: rtl/write_ctrl_gray2bin.sv
// gray2bin: Gray to binary conversion of an ADDR_WIDTH+1 bit pointer (XOR prefix from MSB).
module gray2bin #(parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH_DEF) (
  input logic [ADDR_WIDTH:0] gray,
  output logic [ADDR_WIDTH:0] bin
);
  for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[ADDR_WIDTH:i];
  end
endmodule

// File: rtl/write_ctrl.sv
// write_ctrl: write pointer, read-pointer synchroniser, full/level/overflow of a dual-clock FIFO.
// Registered almost-full is built only when FIFO_ALMOST_FULL_EN is defined.
module write_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF
) (
  input logic w_clk,
  input logic w_rst_n,
  write_ctrl_if.slave bus
);
  localparam int A = ADDR_WIDTH;
  function automatic logic [A:0] bin2gray(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction
  logic [A:0] w_ptr_x, w_ptr_x_next, w_ptr_gray, w_level, w_level_next;
  logic [A:0] r_sync_gray, r_sync_bin;
  logic [A:0] rq [SYNC_STAGES];
  logic w_full, w_en, w_overflow;
  assign r_sync_gray = rq[SYNC_STAGES-1];
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign w_full = w_ptr_gray == {~r_sync_gray[A:A-1], r_sync_gray[A-2:0]};
  assign w_en = bus.w_push && !w_full;
  assign w_ptr_x_next = w_ptr_x + (A+1)'(w_en);
  assign w_level_next = w_ptr_x - r_sync_bin;
  gray2bin #(.ADDR_WIDTH(A)) u_gray2bin (.gray(r_sync_gray), .bin(r_sync_bin));
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      w_ptr_x <= '0;
      w_ptr_gray <= '0;
      w_level <= '0;
      w_overflow <= 1'b0;
      rq <= '{default: '0};
    end else begin
      w_ptr_x <= w_ptr_x_next;
      w_ptr_gray <= bin2gray(w_ptr_x_next);
      w_level <= w_level_next;
      w_overflow <= w_overflow || (bus.w_push && w_full);
      rq[0] <= bus.r_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) rq[i] <= rq[i-1];
    end
`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [A:0] DEPTH = (A+1)'(1) << A;
  localparam logic [A:0] MARGIN = (A+1)'(AF_MARGIN);
  logic w_almost_full;
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) w_almost_full <= 1'b0;
    else w_almost_full <= ((DEPTH - w_level_next) <= MARGIN);
  assign bus.w_almost_full = w_almost_full;
`else
  assign bus.w_almost_full = 1'b0;
`endif
  assign bus.w_en = w_en;
  assign bus.w_ptr = w_ptr_x[A-1:0];
  assign bus.w_ptr_gray = w_ptr_gray;
  assign bus.w_full = w_full;
  assign bus.w_level = w_level;
  assign bus.w_overflow = w_overflow;
endmodule
